mux4_scan_ctrl: RTL and testbench
=================================

Name: mux4_scan_ctrl

Overview:
- Upstream controller for the team's 4:1 bit mux (mux4X1).
- On a start pulse it steps the mux select across the enabled channels. It holds each select for a programmable dwell time, then captures the mux output into a per-channel sample register.
- When the scan finishes it raises a one-cycle done flag together with the assembled 4-bit sample word.
- Lets slow, one-bit-at-a-time consumers reconstruct a 4-bit input bus through the shared mux.

Parameters:
- DWELL, 2: cycles each select value is held before capture; legal range 1..255.
- CW, 8: width of the internal dwell counter; must satisfy DWELL <= 2^CW - 1.

Ports:
- clk      input   1  rising-edge clock
- rst      input   1  synchronous, active-high reset
- start    input   1  scan request; sampled only in IDLE
- chan_en  input   4  channel enable mask; latched when start is accepted
- mux_out  input   1  output of the downstream mux4X1
- sel      output  2  select driven to mux4X1
- busy     output  1  high while a scan is in progress
- done     output  1  one-cycle pulse at scan completion
- sample   output  4  captured channel values; bit n = value seen with sel = n
- parity   output  1  only with MUX_SCAN_PARITY_EN: XOR of sample

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: sel = 0, busy = 0, done = 0, sample = 0, parity = 0, state = IDLE, counter = 0, latched mask = 0.
- States: IDLE, SCAN, FIN.

IDLE:
- busy = 0; sel holds its last value.
- start = 1 and chan_en != 0:
  - latch the mask;
  - clear sample bits of disabled channels to 0;
  - set sel to the lowest enabled index;
  - counter = 0;
  - go to SCAN.
- start = 1 and chan_en == 0:
  - sample becomes 0;
  - go to FIN (done appears the next cycle).

SCAN:
- busy = 1; sel is stable.
- While counter < DWELL-1: counter increments.
- When counter == DWELL-1:
  - sample[sel] <= mux_out;
  - counter <= 0;
  - sel <= next enabled index strictly above the current one;
  - if no such index exists, go to FIN and leave sel unchanged.
- Indices never wrap within a scan.

FIN:
- done = 1 and busy = 0 for exactly one cycle; sample is final and stable.
- Return to IDLE.

Rules and boundary conditions:
- Latency: with k enabled channels, done is high in the cycle beginning k*DWELL+1 edges after the start-accept edge. With k = 0, done is high one edge after accept.
- start while busy or in FIN is ignored; there is no queueing.
- chan_en changes during a scan have no effect, because the latched mask is used.
- DWELL = 1: capture happens on every SCAN cycle, one channel per cycle.
- sample holds its value until the next accepted start; it is never cleared by done.
- rst in any state aborts the scan next edge and forces all reset values; no done is issued.
- A new start in the IDLE cycle right after FIN is accepted normally.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - parity port exists;
  - parity updates in FIN to the XOR of the final sample word;
  - parity holds until the next FIN; reset value 0.
- Undefined:
  - parity port and its logic are absent;
  - all other behaviour is identical.

Test Plan:
1. Bench setup: instantiate mux4X1 between sel and mux_out; drive its i from the bench; DWELL = 2.
2. i = 1010, chan_en = 1111, start pulse -> sel steps 0,1,2,3 with 2 cycles each; done at edge 9 after accept; sample = 1010; parity = 0.
3. i = 1101, chan_en = 0101 -> sel visits 0 then 2 only; sample = 0101 (disabled bits cleared); done at edge 5.
4. chan_en = 0000, start -> busy stays 0; done at edge 1; sample = 0000.
5. Mid-scan of case 2: pulse start and change chan_en to 0001 -> both ignored; result is still 1010 with the original timing.
6. Assert rst during the sel = 2 dwell -> next edge sel = 0, busy = 0, sample = 0, no done pulse; a fresh start with i = 1101 and chan_en = 1111 then yields 1101 and parity = 1.

Source files
------------

// File: rtl/mux4_scan_ctrl_if.sv
// Bus between mux4_scan_ctrl and its user: scan request, mux feedback and scan results.
// The parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux4_scan_ctrl_if;
    logic       start;
    logic [3:0] chan_en;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [3:0] sample;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;
`endif

    modport master (
        output start, chan_en, mux_out,
`ifdef MUX_SCAN_PARITY_EN
        input  parity,
`endif
        input  sel, busy, done, sample
    );

    modport slave (
        input  start, chan_en, mux_out,
`ifdef MUX_SCAN_PARITY_EN
        output parity,
`endif
        output sel, busy, done, sample
    );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Steps a 4:1 mux select over the enabled channels, dwelling DWELL cycles on each, and
// assembles the captured bits into a 4-bit word; MUX_SCAN_PARITY_EN adds a parity output.
module mux4_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux4_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_mask;
    logic [1:0]    r_sel;
    logic          r_busy;
    logic          r_done;
    logic [3:0]    r_sample;
`ifdef MUX_SCAN_PARITY_EN
    logic          r_parity;
`endif

    logic [1:0]    w_first;
    logic [2:0]    w_next;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (m[n]) idx = 2'(n);
        end
        return idx;
    endfunction

    // Returns {found, index} of the lowest enabled channel strictly above cur; never wraps.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        for (int n = 3; n >= 0; n--) begin
            if (m[n] && (n > int'(cur))) res = {1'b1, 2'(n)};
        end
        return res;
    endfunction

    assign w_first = lowest_idx(bus.chan_en);
    assign w_next  = next_above(r_mask, r_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mask   <= 4'd0;
            r_sel    <= 2'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sample <= 4'd0;
`ifdef MUX_SCAN_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.chan_en != 4'd0) begin
                            r_mask   <= bus.chan_en;
                            r_sample <= r_sample & bus.chan_en;
                            r_sel    <= w_first;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= SCAN;
                        end else begin
                            r_sample <= 4'd0;
                            r_state  <= FIN;
                        end
                    end
                end
                SCAN: begin
                    if (r_cnt == LAST) begin
                        r_sample[r_sel] <= bus.mux_out;
                        r_cnt           <= '0;
                        if (w_next[2]) begin
                            r_sel <= w_next[1:0];
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= FIN;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FIN: begin
                    // done and parity become visible together in the following IDLE cycle
                    r_done   <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    r_parity <= ^r_sample;
`endif
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sel    = r_sel;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.sample = r_sample;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.parity = r_parity;
`endif
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: timeline-based reference model plus directed and random scans.
// The mux4X1 is modelled inline as mux_out = i[sel].
module tb_mux4_scan_ctrl;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_vec;

    mux4_scan_ctrl_if bus();
    assign bus.mux_out = i_vec[bus.sel];

    mux4_scan_ctrl #(.DWELL(D), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a scan is a timeline of edges d since accept, over the list of enabled channels.
    bit         m_active = 1'b0;
    int         m_d = 0;
    int         m_k = 0;
    int         m_ch[4];
    logic [1:0] m_sel = 2'd0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_sample = 4'd0;
    logic       m_parity = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic [3:0] en, input logic [3:0] iv,
                              input logic r);
        int j;
        if (r) begin
            m_active = 1'b0; m_sel = 2'd0; m_busy = 1'b0; m_done = 1'b0;
            m_sample = 4'd0; m_parity = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (m_active) begin
            m_d++;
            if (m_k > 0 && m_d <= m_k * D && (m_d % D) == 0) begin
                j = m_ch[m_d / D - 1];
                m_sample[j] = iv[j];
            end
            if (m_d < m_k * D) m_sel = 2'(m_ch[m_d / D]);
            m_busy = (m_d < m_k * D);
            if (m_d == m_k * D + 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_parity = ^m_sample;
            end
        end else if (st) begin
            m_k = 0;
            for (int n = 0; n < 4; n++) begin
                if (en[n]) begin
                    m_ch[m_k] = n;
                    m_k++;
                end
            end
            m_active = 1'b1;
            m_d      = 0;
            if (m_k > 0) begin
                m_sample = m_sample & en;
                m_sel    = 2'(m_ch[0]);
                m_busy   = 1'b1;
            end else begin
                m_sample = 4'd0;
                m_busy   = 1'b0;
            end
        end
    endtask

    // Drive one edge's inputs, advance the model over that edge, then compare after it.
    task automatic tick(input logic st, input logic [3:0] en, input logic [3:0] iv, input logic r);
        rst         = r;
        bus.start   = st;
        bus.chan_en = en;
        i_vec       = iv;
        model_edge(st, en, iv, r);
        @(negedge clk);
        chk("sel",    32'(bus.sel),    32'(m_sel));
        chk("busy",   32'(bus.busy),   32'(m_busy));
        chk("done",   32'(bus.done),   32'(m_done));
        chk("sample", 32'(bus.sample), 32'(m_sample));
`ifdef MUX_SCAN_PARITY_EN
        chk("parity", 32'(bus.parity), 32'(m_parity));
`endif
    endtask

    // Accept a start, then run until done; at edge 'poke' a stray start with mask 0001 is driven.
    task automatic scan(input logic [3:0] en, input logic [3:0] iv, input int poke, output int lat);
        tick(1'b1, en, iv, 1'b0);
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            tick(n == poke, (n == poke) ? 4'b0001 : en, iv, 1'b0);
            if (bus.done === 1'b1) lat = n;
        end
        chk("done_seen", 32'(lat >= 0), 32'd1);
    endtask

    initial begin
        int lat;
        logic [3:0] r_en, r_iv;
        logic r_st, r_rs;

        tick(1'b0, 4'd0, 4'd0, 1'b1);
        tick(1'b0, 4'd0, 4'd0, 1'b1);
        chk("reset_sel",    32'(bus.sel),    32'd0);
        chk("reset_busy",   32'(bus.busy),   32'd0);
        chk("reset_sample", 32'(bus.sample), 32'd0);
        tick(1'b0, 4'd0, 4'd0, 1'b0);

        scan(4'b1111, 4'b1010, 0, lat);
        chk("full_latency", 32'(lat), 32'd9);
        chk("full_sample",  32'(bus.sample), 32'b1010);
`ifdef MUX_SCAN_PARITY_EN
        chk("full_parity",  32'(bus.parity), 32'd0);
`endif

        scan(4'b0101, 4'b1101, 0, lat);
        chk("sparse_latency", 32'(lat), 32'd5);
        chk("sparse_sample",  32'(bus.sample), 32'b0101);

        scan(4'b0000, 4'b1111, 0, lat);
        chk("empty_latency", 32'(lat), 32'd1);
        chk("empty_sample",  32'(bus.sample), 32'd0);

        scan(4'b1111, 4'b1010, 3, lat);
        chk("poke_latency", 32'(lat), 32'd9);
        chk("poke_sample",  32'(bus.sample), 32'b1010);

        tick(1'b1, 4'b1111, 4'b1010, 1'b0);
        for (int n = 0; n < 20 && bus.sel !== 2'd2; n++) tick(1'b0, 4'b1111, 4'b1010, 1'b0);
        chk("reach_sel2", 32'(bus.sel), 32'd2);
        tick(1'b0, 4'b1111, 4'b1010, 1'b1);
        chk("abort_sel",    32'(bus.sel),    32'd0);
        chk("abort_busy",   32'(bus.busy),   32'd0);
        chk("abort_done",   32'(bus.done),   32'd0);
        chk("abort_sample", 32'(bus.sample), 32'd0);
        tick(1'b0, 4'b1111, 4'b1101, 1'b0);
        scan(4'b1111, 4'b1101, 0, lat);
        chk("after_abort_latency", 32'(lat), 32'd9);
        chk("after_abort_sample",  32'(bus.sample), 32'b1101);
`ifdef MUX_SCAN_PARITY_EN
        chk("after_abort_parity",  32'(bus.parity), 32'd1);
`endif

        for (int n = 0; n < 400; n++) begin
            r_rs = ($urandom_range(0, 63) == 0);
            r_st = ($urandom_range(0, 3) == 0);
            r_en = 4'($urandom);
            r_iv = 4'($urandom);
            tick(r_st, r_en, r_iv, r_rs);
        end
        for (int n = 0; n < 12; n++) tick(1'b0, 4'd0, 4'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
